// File: rtl/nrisc_pkg.sv
// nRisc shared datapath types and constants.
// Imported by the operand select pipeline.
package nrisc_pkg;

  localparam int WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/operand_skid.sv
// Two-entry valid/ready register slice.
// Output reg O plus skid reg S; in_ready is registered.
module operand_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             rst_n_q;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             accept;

  assign in_ready  = rst_n_q & ~s_valid;
  assign accept    = in_valid & in_ready;
  assign out_valid = o_valid;
  assign out_data  = o_data;

  // Strict FIFO slice: O never overwritten while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
    end else begin
      rst_n_q <= 1'b1;
      if (s_valid) begin
        if (out_ready) begin
          o_data  <= s_data;
          s_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!o_valid || out_ready) begin
          o_data  <= in_data;
          o_valid <= 1'b1;
        end else begin
          s_data  <= in_data;
          s_valid <= 1'b1;
        end
      end else if (o_valid && out_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// Registered N-source / immediate operand selector.
// Selection and extension feed an operand_skid slice.
module operand_sel_pipe
  import nrisc_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int NUM_SRC = 4,
  parameter int IMM_W   = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [IMM_W-1:0]         imm,
  input  logic                     imm_en,
  input  logic                     sext,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     sel_err
);

  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] operand;
  logic             sel_oor;
  logic             fill;

  assign fill = (sext == EXT_SIGN) & imm[IMM_W-1];

  generate
    if (IMM_W == WIDTH) begin : g_pass
      assign ext = imm;
    end else begin : g_ext
      assign ext = {{(WIDTH-IMM_W){fill}}, imm};
    end
  endgenerate

  assign sel_oor = ~imm_en & (32'(sel) >= NUM_SRC);

  // Operand mux; out-of-range select yields zero.
  always_comb begin
    operand = '0;
    if (imm_en) begin
      operand = ext;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (32'(sel) == k) begin
          operand = src_flat[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Sticky flag for accepted out-of-range selects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (in_valid && in_ready && sel_oor) begin
      sel_err <= 1'b1;
    end
  end

  operand_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (operand),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule
